// File: rtl/poly_tone_gen.sv
// poly_tone_gen: NCH-voice square-wave tone generator with a shared octave and
// run/pause state, per-voice tone outputs and a 1-bit PWM mix for one speaker pin.
module poly_tone_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int NCH     = 4,
  parameter int CNT_W   = 24,
  parameter int OCT_MAX = 7,
  parameter int OCT_RST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_gate,
  input  logic [4*NCH-1:0] ch_note,
  input  logic             pause,
  input  logic             oct_up,
  input  logic             oct_dn,
  input  logic             oct_load,
  input  logic [2:0]       oct_in,
  output logic             run,
  output logic [2:0]       octave,
  output logic [NCH-1:0]   tone,
  output logic             mix_pwm
);

  localparam int SW = $clog2(NCH + 1);

  localparam logic [2:0]       OCT_TOP   = 3'(OCT_MAX);
  localparam logic [2:0]       OCT_INIT  = 3'(OCT_RST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SW-1:0]    PWM_LAST  = SW'(NCH - 1);

  // Half-period in clock cycles at octave 0 for each of the 16 notes.
  localparam logic [CNT_W-1:0] BASE [16] = '{
    CNT_W'(CLK_HZ / 3729), CNT_W'(CLK_HZ / 3951), CNT_W'(CLK_HZ / 4186), CNT_W'(CLK_HZ / 4434),
    CNT_W'(CLK_HZ / 4698), CNT_W'(CLK_HZ / 4978), CNT_W'(CLK_HZ / 5274), CNT_W'(CLK_HZ / 5587),
    CNT_W'(CLK_HZ / 5919), CNT_W'(CLK_HZ / 6271), CNT_W'(CLK_HZ / 6644), CNT_W'(CLK_HZ / 7040),
    CNT_W'(CLK_HZ / 7458), CNT_W'(CLK_HZ / 7902), CNT_W'(CLK_HZ / 8372), CNT_W'(CLK_HZ / 8869)
  };

  typedef enum logic {
    IDLE,
    PLAY
  } voice_state_t;

  // pause is independent of the octave controls; oct_load outranks up/down,
  // and up+down together or a step past either end leaves the octave alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      octave <= OCT_INIT;
    end else begin
      if (pause) begin
        run <= ~run;
      end
      if (oct_load) begin
        octave <= (oct_in > OCT_TOP) ? OCT_TOP : oct_in;
      end else if (oct_up && !oct_dn && (octave < OCT_TOP)) begin
        octave <= octave + 3'd1;
      end else if (oct_dn && !oct_up && (octave != 3'd0)) begin
        octave <= octave - 3'd1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_voice
    voice_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] div_now;
    logic             tone_q;

    assign div_now = BASE[ch_note[4*i +: 4]] << octave;
    assign tone[i] = tone_q;

    // The divisor is only re-sampled at a toggle, so note and octave changes
    // never shorten or stretch a half-period that is already under way.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= IDLE;
        cnt    <= '0;
        div    <= '0;
        tone_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt    <= '0;
            tone_q <= 1'b0;
            if (ch_gate[i]) begin
              state <= PLAY;
              div   <= div_now;
            end
          end
          PLAY: begin
            if (!ch_gate[i]) begin
              state  <= IDLE;
              cnt    <= '0;
              tone_q <= 1'b0;
            end else if (run) begin
              if (cnt == div - CNT_ONE) begin
                cnt    <= '0;
                tone_q <= ~tone_q;
                div    <= div_now;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  logic [SW-1:0] active;
  logic [SW-1:0] sum;
  logic [SW-1:0] pwm_cnt;

  always_comb begin
    active = '0;
    for (int i = 0; i < NCH; i++) begin
      active = active + SW'(tone[i]);
    end
  end

  // pwm_cnt sweeps 0..NCH-1 regardless of run, so the duty cycle of mix_pwm
  // is sum/NCH with all-on and all-off giving a steady level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      pwm_cnt <= '0;
      mix_pwm <= 1'b0;
    end else begin
      sum     <= active;
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + SW'(1);
      mix_pwm <= (pwm_cnt < sum);
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// tb_poly_tone_gen: directed stimulus for poly_tone_gen, checked every cycle
// against a behavioural model plus hand-computed half-period and mix expectations.
module tb_poly_tone_gen;

  localparam int CLK_HZ  = 100000;
  localparam int NCH     = 4;
  localparam int OCT_MAX = 7;
  localparam int OCT_RST = 4;
  localparam int LIMIT   = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_gate = '0;
  logic [15:0] ch_note = '0;
  logic        pause = 1'b0;
  logic        oct_up = 1'b0;
  logic        oct_dn = 1'b0;
  logic        oct_load = 1'b0;
  logic [2:0]  oct_in = '0;
  logic        run;
  logic [2:0]  octave;
  logic [3:0]  tone;
  logic        mix_pwm;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  poly_tone_gen #(
    .CLK_HZ(CLK_HZ), .NCH(NCH), .CNT_W(24), .OCT_MAX(OCT_MAX), .OCT_RST(OCT_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_gate(ch_gate), .ch_note(ch_note),
    .pause(pause), .oct_up(oct_up), .oct_dn(oct_dn), .oct_load(oct_load),
    .oct_in(oct_in), .run(run), .octave(octave), .tone(tone), .mix_pwm(mix_pwm)
  );

  always #5 clk = ~clk;

  // Behavioural model: notes are frequencies, a voice flips after a whole
  // half-period of running cycles, and the mix is a delayed duty-cycle compare.
  int FREQ [16] = '{3729, 3951, 4186, 4434, 4698, 4978, 5274, 5587,
                    5919, 6271, 6644, 7040, 7458, 7902, 8372, 8869};

  function automatic int half_period(input int note, input int oct);
    return (CLK_HZ / FREQ[note]) * (1 << oct);
  endfunction

  bit         m_run;
  int         m_oct;
  bit         m_play [NCH];
  int         m_elapsed [NCH];
  int         m_half [NCH];
  logic [3:0] m_tone;
  int         m_sum;
  int         m_phase;
  bit         m_mix;
  bit         t_mix;
  int         t_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_oct = OCT_RST;
      m_tone = '0;
      m_sum = 0;
      m_phase = 0;
      m_mix = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_play[i] = 1'b0;
        m_elapsed[i] = 0;
        m_half[i] = 0;
      end
    end else begin
      t_mix = (m_phase < m_sum);
      t_sum = $countones(m_tone);
      for (int i = 0; i < NCH; i++) begin
        if (!ch_gate[i]) begin
          m_play[i] = 1'b0;
          m_elapsed[i] = 0;
          m_tone[i] = 1'b0;
        end else if (!m_play[i]) begin
          m_play[i] = 1'b1;
          m_elapsed[i] = 0;
          m_half[i] = half_period(int'(ch_note[4*i +: 4]), m_oct);
        end else if (m_run) begin
          m_elapsed[i] = m_elapsed[i] + 1;
          if (m_elapsed[i] >= m_half[i]) begin
            m_tone[i] = ~m_tone[i];
            m_elapsed[i] = 0;
            m_half[i] = half_period(int'(ch_note[4*i +: 4]), m_oct);
          end
        end
      end
      m_mix = t_mix;
      m_sum = t_sum;
      m_phase = (m_phase + 1) % NCH;
      if (pause) m_run = !m_run;
      if (oct_load) m_oct = (int'(oct_in) > OCT_MAX) ? OCT_MAX : int'(oct_in);
      else if (oct_up && !oct_dn) m_oct = (m_oct + 1 > OCT_MAX) ? OCT_MAX : m_oct + 1;
      else if (oct_dn && !oct_up) m_oct = (m_oct - 1 < 0) ? 0 : m_oct - 1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_run", int'(run), int'(m_run));
      checkOutput("model_octave", int'(octave), m_oct);
      checkOutput("model_tone", int'(tone), int'(m_tone));
      checkOutput("model_mix", int'(mix_pwm), int'(m_mix));
    end
  end

  task automatic applyStimulus(input logic p, input logic u, input logic d,
                               input logic l, input logic [2:0] v);
    pause = p;
    oct_up = u;
    oct_dn = d;
    oct_load = l;
    oct_in = v;
    @(negedge clk);
    pause = 1'b0;
    oct_up = 1'b0;
    oct_dn = 1'b0;
    oct_load = 1'b0;
  endtask

  task automatic wait_toggle(output int n);
    logic start;
    start = tone[0];
    n = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (tone[0] != start) begin
        n = k;
        break;
      end
    end
    if (n < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL toggle_timeout: no tone[0] edge within %0d cycles", LIMIT);
    end
  endtask

  int n;
  int ones;
  int z0;
  int z1;

  initial begin
    checkOutput("model_base0", half_period(0, 0), 26);
    checkOutput("model_base15", half_period(15, 0), 11);
    checkOutput("model_oct3", half_period(0, 3), 208);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    checkOutput("rst_run", int'(run), 0);
    checkOutput("rst_octave", int'(octave), OCT_RST);
    checkOutput("rst_tone", int'(tone), 0);
    checkOutput("rst_mix", int'(mix_pwm), 0);

    // Basic tone on voice 0
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkOutput("run_on", int'(run), 1);
    checkOutput("oct_load0", int'(octave), 0);
    ch_note[3:0] = 4'd0;
    ch_gate[0] = 1'b1;
    @(negedge clk);
    wait_toggle(n);
    checkOutput("first_half_n0", n, 26);
    wait_toggle(n);
    checkOutput("half_n0", n, 26);
    checkOutput("others_silent", int'(tone[3:1]), 0);

    // Octave steps and saturation
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("oct_up3", int'(octave), 3);
    wait_toggle(n);
    wait_toggle(n);
    checkOutput("half_oct3", n, 208);
    ch_gate[0] = 1'b0;
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("oct_sat_hi", int'(octave), 7);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    checkOutput("oct_sat_lo", int'(octave), 0);

    // Note change mid half-period takes effect at the next edge
    ch_note[3:0] = 4'd0;
    ch_gate[0] = 1'b1;
    @(negedge clk);
    wait_toggle(n);
    checkOutput("regate_half", n, 26);
    repeat (10) @(negedge clk);
    ch_note[3:0] = 4'd15;
    wait_toggle(n);
    checkOutput("note_change_rest", n, 26 - 10);
    wait_toggle(n);
    checkOutput("half_n15_a", n, 11);
    wait_toggle(n);
    checkOutput("half_n15_b", n, 11);

    // Pause freezes the divider mid half-period
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("paused", int'(run), 0);
    repeat (20) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("resumed", int'(run), 1);
    wait_toggle(n);
    checkOutput("pause_rest", n, 11 - 5);

    // Gate drop clears the voice next cycle; re-gate restarts a full half-period
    if (tone[0] == 1'b0) wait_toggle(n);
    repeat (3) @(negedge clk);
    ch_gate[0] = 1'b0;
    @(negedge clk);
    checkOutput("gate_drop_tone", int'(tone[0]), 0);
    ch_gate[0] = 1'b1;
    @(negedge clk);
    wait_toggle(n);
    checkOutput("regate_n15", n, 11);

    // Three voices high, one low: mix duty 3 of 4
    ch_gate = 4'b0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    ch_note = 16'hFFFF;
    ch_gate = 4'b0111;
    @(negedge clk);
    wait_toggle(n);
    checkOutput("half_n15_oct2", n, 44);
    checkOutput("three_voices", int'(tone), 7);
    repeat (3) @(negedge clk);
    ones = 0;
    z0 = -100;
    z1 = -100;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mix_pwm) ones++;
      else if (z0 < 0) z0 = k;
      else z1 = k;
    end
    checkOutput("mix_ones", ones, 6);
    checkOutput("mix_zero_gap", z1 - z0, 4);

    // Control priority corners
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkOutput("up_dn_hold", int'(octave), 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("pause_with_up_run", int'(run), 0);
    checkOutput("pause_with_up_oct", int'(octave), 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    checkOutput("load_beats_up", int'(octave), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-note
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_run", int'(run), 0);
    checkOutput("arst_octave", int'(octave), OCT_RST);
    checkOutput("arst_tone", int'(tone), 0);
    checkOutput("arst_mix", int'(mix_pwm), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
